// File: rtl/rr_priority_arbiter.sv
// rr_priority_arbiter: eight-requester round-robin arbiter, MSB-first search from a rotating pointer,
// with each ownership capped at MAX_HOLD consecutive cycles.
module rr_priority_arbiter #(
    parameter int MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] req,
    output logic [7:0] grant,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic       preempt,
    output logic [2:0] ptr
);
    typedef enum logic {IDLE, OWNED} state_t;
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
    state_t     state, state_nx;
    logic [2:0] owner, owner_nx, ptr_nx, rel_ptr, idx_nx;
    logic [7:0] hold_cnt, hold_nx, grant_nx;
    logic [3:0] win_idle, win_rel;
    logic       preempt_nx, valid_nx;
    // Returns {found, index}; scanning from the far end lets the pointer position win last.
    function automatic logic [3:0] search(input logic [2:0] p, input logic [7:0] r);
        logic [3:0] w;
        logic [2:0] k;
        w = '0;
        for (int i = 7; i >= 0; i--) begin
            k = p - 3'(i);
            if (r[k]) w = {1'b1, k};
        end
        return w;
    endfunction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            owner     <= '0;
            hold_cnt  <= '0;
            ptr       <= 3'd7;
            grant     <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            preempt   <= 1'b0;
        end else begin
            state     <= state_nx;
            owner     <= owner_nx;
            hold_cnt  <= hold_nx;
            ptr       <= ptr_nx;
            grant     <= grant_nx;
            gnt_idx   <= idx_nx;
            gnt_valid <= valid_nx;
            preempt   <= preempt_nx;
        end
    end
    always_comb begin
        state_nx   = state;
        owner_nx   = owner;
        hold_nx    = hold_cnt;
        ptr_nx     = ptr;
        preempt_nx = 1'b0;
        rel_ptr    = owner - 3'd1;
        win_idle   = search(ptr, req);
        win_rel    = search(rel_ptr, req);
        if (!en) begin
            state_nx = IDLE;
            hold_nx  = '0;
        end else if (state == IDLE) begin
            if (win_idle[3]) begin
                state_nx = OWNED;
                owner_nx = win_idle[2:0];
                hold_nx  = '0;
            end
        end else if (req[owner] && hold_cnt < HOLD_LAST) begin
            hold_nx = hold_cnt + 8'd1;
        end else begin
            // Release or hold-limit expiry: owner drops to lowest priority and re-search happens now.
            ptr_nx     = rel_ptr;
            preempt_nx = req[owner];
            hold_nx    = '0;
            state_nx   = win_rel[3] ? OWNED : IDLE;
            owner_nx   = win_rel[3] ? win_rel[2:0] : owner;
        end
    end
    always_comb begin
        valid_nx = state_nx == OWNED;
        idx_nx   = valid_nx ? owner_nx : 3'd0;
        grant_nx = valid_nx ? 8'd1 << owner_nx : 8'd0;
    end
endmodule

// File: tb/tb_rr_priority_arbiter.sv
// tb_rr_priority_arbiter: table-driven directed checks of rr_priority_arbiter plus hand-written
// sequences for asynchronous reset and MAX_HOLD=1 rotation.
module tb_rr_priority_arbiter;
    logic       clk = 1'b0, rst_n = 1'b0, en = 1'b0;
    logic [7:0] req = '0;
    logic [7:0] grant, grant1;
    logic [2:0] gnt_idx, idx1, ptr, ptr1;
    logic       gnt_valid, valid1, preempt, preempt1;
    int passed = 0, total = 0;

    always #5 clk = ~clk;

    rr_priority_arbiter #(.MAX_HOLD(4)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req),
        .grant(grant), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid), .preempt(preempt), .ptr(ptr)
    );
    rr_priority_arbiter #(.MAX_HOLD(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req),
        .grant(grant1), .gnt_idx(idx1), .gnt_valid(valid1), .preempt(preempt1), .ptr(ptr1)
    );

    typedef struct {
        logic        rst_n;
        logic        en;
        logic [7:0]  req;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl[36];

    // Packed output tuple: {grant, gnt_idx, gnt_valid, preempt, ptr}
    function automatic logic [15:0] pk(input logic [7:0] g, input logic [2:0] i,
                                       input logic p, input logic [2:0] pt);
        return {g, i, g != 8'd0, p, pt};
    endfunction

    function automatic vec_t mk(input logic r, input logic e, input logic [7:0] q,
                                input logic [7:0] g, input logic [2:0] i,
                                input logic p, input logic [2:0] pt);
        vec_t v;
        v.rst_n = r;
        v.en    = e;
        v.req   = q;
        v.exp   = pk(g, i, p, pt);
        return v;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got {grant,idx,valid,preempt,ptr}=%h expected %h", name, act, exp);
    endtask

    initial begin
        tbl[0]  = mk(0, 1, 8'hFF, 8'h00, 0, 0, 7);
        tbl[1]  = mk(0, 1, 8'hFF, 8'h00, 0, 0, 7);
        tbl[2]  = mk(1, 1, 8'hFF, 8'h80, 7, 0, 7);
        tbl[3]  = mk(1, 1, 8'h00, 8'h00, 0, 0, 6);
        tbl[4]  = mk(1, 1, 8'h04, 8'h04, 2, 0, 6);
        tbl[5]  = mk(1, 1, 8'h04, 8'h04, 2, 0, 6);
        tbl[6]  = mk(1, 1, 8'h00, 8'h00, 0, 0, 1);
        tbl[7]  = mk(0, 1, 8'h81, 8'h00, 0, 0, 7);
        tbl[8]  = mk(1, 1, 8'h81, 8'h80, 7, 0, 7);
        tbl[9]  = mk(1, 1, 8'h81, 8'h80, 7, 0, 7);
        tbl[10] = mk(1, 1, 8'h81, 8'h80, 7, 0, 7);
        tbl[11] = mk(1, 1, 8'h81, 8'h80, 7, 0, 7);
        tbl[12] = mk(1, 1, 8'h81, 8'h01, 0, 1, 6);
        tbl[13] = mk(1, 1, 8'h81, 8'h01, 0, 0, 6);
        tbl[14] = mk(1, 1, 8'h81, 8'h01, 0, 0, 6);
        tbl[15] = mk(1, 1, 8'h81, 8'h01, 0, 0, 6);
        tbl[16] = mk(1, 1, 8'h81, 8'h80, 7, 1, 7);
        tbl[17] = mk(1, 1, 8'h81, 8'h80, 7, 0, 7);
        tbl[18] = mk(1, 1, 8'h01, 8'h01, 0, 0, 6);
        tbl[19] = mk(1, 1, 8'h00, 8'h00, 0, 0, 7);
        tbl[20] = mk(1, 1, 8'h10, 8'h10, 4, 0, 7);
        tbl[21] = mk(1, 1, 8'h10, 8'h10, 4, 0, 7);
        tbl[22] = mk(1, 1, 8'h10, 8'h10, 4, 0, 7);
        tbl[23] = mk(1, 1, 8'h10, 8'h10, 4, 0, 7);
        tbl[24] = mk(1, 1, 8'h10, 8'h10, 4, 1, 3);
        tbl[25] = mk(1, 1, 8'h10, 8'h10, 4, 0, 3);
        tbl[26] = mk(1, 1, 8'h10, 8'h10, 4, 0, 3);
        tbl[27] = mk(1, 1, 8'h10, 8'h10, 4, 0, 3);
        tbl[28] = mk(1, 1, 8'h10, 8'h10, 4, 1, 3);
        tbl[29] = mk(1, 1, 8'h10, 8'h10, 4, 0, 3);
        tbl[30] = mk(1, 1, 8'h08, 8'h08, 3, 0, 3);
        tbl[31] = mk(1, 0, 8'h08, 8'h00, 0, 0, 3);
        tbl[32] = mk(1, 1, 8'h0C, 8'h08, 3, 0, 3);
        tbl[33] = mk(1, 1, 8'h04, 8'h04, 2, 0, 2);
        tbl[34] = mk(1, 0, 8'hFF, 8'h00, 0, 0, 2);
        tbl[35] = mk(1, 1, 8'hFF, 8'h04, 2, 0, 2);

        @(negedge clk);
        for (int i = 0; i < 36; i++) begin
            rst_n = tbl[i].rst_n;
            en    = tbl[i].en;
            req   = tbl[i].req;
            @(negedge clk);
            check($sformatf("vec%0d", i), {grant, gnt_idx, gnt_valid, preempt, ptr}, tbl[i].exp);
        end

        // Asynchronous reset while index 2 holds the grant: outputs must clear before any edge.
        #2 rst_n = 1'b0;
        #1;
        check("async_rst", {grant, gnt_idx, gnt_valid, preempt, ptr}, pk(8'h00, 0, 0, 7));
        check("async_rst_h1", {grant1, idx1, valid1, preempt1, ptr1}, pk(8'h00, 0, 0, 7));

        // MAX_HOLD=1 rotates every cycle while MAX_HOLD=4 keeps its owner.
        @(negedge clk);
        rst_n = 1'b1;
        en    = 1'b1;
        req   = 8'hFF;
        @(negedge clk);
        check("h4_c1", {grant, gnt_idx, gnt_valid, preempt, ptr}, pk(8'h80, 7, 0, 7));
        check("h1_c1", {grant1, idx1, valid1, preempt1, ptr1}, pk(8'h80, 7, 0, 7));
        @(negedge clk);
        check("h4_c2", {grant, gnt_idx, gnt_valid, preempt, ptr}, pk(8'h80, 7, 0, 7));
        check("h1_c2", {grant1, idx1, valid1, preempt1, ptr1}, pk(8'h40, 6, 1, 6));
        @(negedge clk);
        check("h4_c3", {grant, gnt_idx, gnt_valid, preempt, ptr}, pk(8'h80, 7, 0, 7));
        check("h1_c3", {grant1, idx1, valid1, preempt1, ptr1}, pk(8'h20, 5, 1, 5));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/rr_priority_arbiter.md
# rr_priority_arbiter

Eight-requester round-robin arbiter with a bounded grant hold. It shares a single downstream resource, such as the 8-input priority-encoded datapath, between eight requesters. The search is MSB-first from a rotating priority pointer, so immediately after reset it resolves exactly like a fixed 7-down-to-0 priority encoder. Once arbitration starts, priority rotates for fairness, and each requester's ownership is capped at `MAX_HOLD` cycles.

## Interface
- `MAX_HOLD`, default 4: maximum consecutive grant cycles per ownership. Legal range 1..255.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `en` input 1: arbiter enable. When low, no grant is issued and any current grant is dropped.
- `req` input 8: request vector; `req[k]` high means requester k wants the resource.
- `grant` output 8: one-hot grant, or all zeros.
- `gnt_idx` output 3: binary index of the granted requester; 0 when `gnt_valid` is low.
- `gnt_valid` output 1: high whenever `grant` is non-zero.
- `preempt` output 1: one-cycle pulse on the cycle after a grant is forcibly ended by the hold limit.
- `ptr` output 3: current highest-priority index (debug/observability).

## Operation
- **State:**
  - FSM with two states, IDLE and OWNED.
  - Registers: `owner[2:0]`, `hold_cnt[7:0]`, `ptr[2:0]`.
- **Search order:** `ptr`, `ptr-1`, ..., `ptr-7`, all mod 8. The first index with `req` high wins.
- **IDLE:**
  - If `en` is high and `req` is non-zero: grant the search winner, go to OWNED, `hold_cnt`=0.
  - Otherwise stay in IDLE with all outputs zero.
- **OWNED, hold case:** if `en` is high, `req[owner]` is high, and `hold_cnt` < `MAX_HOLD`-1:
  - keep the grant;
  - increment `hold_cnt`.
- **OWNED, release:** occurs when `req[owner]` is low.
  - Set `ptr` = `owner`-1 mod 8, so the owner becomes lowest priority.
  - Re-search `req` with the new `ptr` in the same cycle.
  - If there is a winner, grant it directly (back-to-back handoff, no gap) and reset `hold_cnt`=0.
  - If there is no winner, go to IDLE.
- **OWNED, forced release:** occurs when `req[owner]` is high and `hold_cnt`==`MAX_HOLD`-1.
  - Handled exactly as release.
  - Additionally assert `preempt` for one cycle.
  - If the owner is the only requester, it is re-granted with `hold_cnt`=0, and `preempt` still pulses.
- **`en` low:** in any state, go to IDLE next edge with all outputs zero. `ptr` is unchanged.
- **Output invariants:** `grant`, `gnt_idx` and `gnt_valid` are all registered and mutually consistent. `grant` is never more than one-hot.

## Timing
- **Reset** (`rst_n` low, asynchronous):
  - `grant`=0, `gnt_idx`=0, `gnt_valid`=0, `preempt`=0;
  - `ptr`=7, state IDLE, `hold_cnt`=0, `owner`=0.
- **Reset mid-grant:** outputs clear immediately, without waiting for a clock edge.
- **First edge after reset release:** normal arbitration.
- **Request-to-grant latency:** `req` sampled at edge N gives `grant` visible after edge N; 1 cycle from request assertion.
- **Release latency:** `req[owner]` low sampled at edge N means the old grant deasserts after edge N. The new grant, if any, appears in the same cycle.
- **Hold bound:** maximum continuous ownership is `MAX_HOLD` cycles. With `MAX_HOLD`=1, priority rotates every cycle.
- **Pointer wrap:** owner 0 released gives `ptr`=7.
- **Simultaneous events:**
  - `en` low overrides every grant/release decision.
  - A release and a new request arriving on the same edge are resolved in that same edge's search.

## Test plan
- **Reset/default priority:** hold `rst_n` low with `req`=8'hFF, then release with `en`=1.
  - During reset: all outputs 0, `ptr`=7.
  - One cycle after release: `grant`=8'h80, `gnt_idx`=7.
- **Single requester, short hold:** `req`=8'h04 for 2 cycles, then 0 (`MAX_HOLD`=4).
  - `grant`=8'h04 for 2 cycles, then 0.
  - `ptr`=1, no `preempt`.
- **Contention rotation:** `req`=8'h81 held constant, `MAX_HOLD`=4.
  - Expected sequence: 7 for 4 cycles (`preempt`, `ptr`→6), 0 for 4 cycles (`preempt`, `ptr`→7), then 7 again.
  - No idle gap between grants.
- **Sole requester at hold limit:** `req`=8'h10 held for 10 cycles, `MAX_HOLD`=4.
  - `grant` stays 8'h10 continuously.
  - `preempt` pulses after cycles 4 and 8.
- **Enable drop mid-grant:** grant to index 3 active, then `en`=0 for one cycle.
  - Next cycle: outputs 0, `ptr` unchanged.
  - When `en` returns to 1: re-arbitrate from the unchanged `ptr`.
- **Asynchronous reset mid-grant and wrap:**
  - Grant to index 0, release, and check `ptr`=7.
  - Then assert `rst_n` low between edges and check outputs clear immediately, without waiting for a clock edge.
